// File: rtl/bundle_fetch_unit.sv
// Fetch front-end: PC + MMU handshake, bundle FIFO, and one-at-a-time issue to the FUs.
// Define FETCH_PERF_CNT_EN to add the saturating starveCycles counter output.
module bundle_fetch_unit #(
  parameter int NFU   = 2,
  parameter int DEPTH = 4,
  localparam int BUNDLEBYTES = NFU * 4,
  localparam int OFFBITS     = $clog2(BUNDLEBYTES),
  localparam int CNTW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirectValid,
  input  logic [63:0]       redirectAddr,
  output logic              doFetch,
  output logic [63:0]       fetchAddress,
  input  logic [NFU*32-1:0] fetchInstruction,
  input  logic              doneFetch,
  input  logic [NFU-1:0]    fuWorking,
  output logic              instructionReady,
  output logic [NFU*32-1:0] bundle,
  output logic [63:0]       bundleAddr,
  output logic [CNTW-1:0]   queueCount
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       starveCycles
`endif
);

  localparam int PTRW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e              state_q;
  logic [63:0]         pc_q;
  logic [63:0]         fetch_addr_q;
  logic                do_fetch_q;
  logic                discard_q;
  logic                holdoff_q;
  logic [PTRW-1:0]     wr_ptr_q;
  logic [PTRW-1:0]     rd_ptr_q;
  logic [CNTW-1:0]     count_q;
  logic [CNTW-1:0]     count_d;
  logic                ready_q;
  logic [NFU*32-1:0]   bundle_q;
  logic [63:0]         bundle_addr_q;

  logic [NFU*32-1:0]   data_mem [DEPTH];
  logic [63:0]         addr_mem [DEPTH];

  logic                push;
  logic                pop;
  logic [63:0]         redirect_pc;
  logic                unused_redirect_lsbs;

  assign redirect_pc          = {redirectAddr[63:OFFBITS], {OFFBITS{1'b0}}};
  assign unused_redirect_lsbs = ^redirectAddr[OFFBITS-1:0];

  // A completion that lands together with a redirect belongs to the old stream.
  assign push = (state_q == WAIT) && doneFetch && !discard_q && !redirectValid;
  assign pop  = (count_q != '0) && (fuWorking == '0) && !holdoff_q && !redirectValid;

  always_comb begin
    count_d = count_q;
    if (redirectValid)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNTW'(1);
    else if (!push && pop)
      count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      fetch_addr_q <= '0;
      do_fetch_q   <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      do_fetch_q <= 1'b0;
      if (redirectValid)
        pc_q <= redirect_pc;
      case (state_q)
        IDLE: begin
          if (!redirectValid && (count_q < CNTW'(DEPTH))) begin
            state_q      <= WAIT;
            do_fetch_q   <= 1'b1;
            fetch_addr_q <= pc_q;
          end
        end
        WAIT: begin
          if (doneFetch) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            if (push)
              pc_q <= pc_q + 64'(BUNDLEBYTES);
          end else if (redirectValid) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= fetchInstruction;
      addr_mem[wr_ptr_q] <= fetch_addr_q;
    end
  end

  // Issue stage: holdoff gives the FUs one cycle to raise fuWorking after a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      holdoff_q     <= 1'b0;
      bundle_q      <= '0;
      bundle_addr_q <= '0;
    end else begin
      count_q   <= count_d;
      ready_q   <= pop;
      holdoff_q <= pop;
      if (redirectValid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + PTRW'(1);
        if (pop) begin
          rd_ptr_q      <= rd_ptr_q + PTRW'(1);
          bundle_q      <= data_mem[rd_ptr_q];
          bundle_addr_q <= addr_mem[rd_ptr_q];
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_q <= '0;
    else if ((fuWorking == '0) && (count_q == '0) && !redirectValid && (starve_q != '1))
      starve_q <= starve_q + 32'd1;
  end

  assign starveCycles = starve_q;
`endif

  assign doFetch          = do_fetch_q;
  assign fetchAddress     = fetch_addr_q;
  assign instructionReady = ready_q;
  assign bundle           = bundle_q;
  assign bundleAddr       = bundle_addr_q;
  assign queueCount       = count_q;

endmodule

// File: tb/tb_bundle_fetch_unit.sv
// Bench for bundle_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_bundle_fetch_unit;

  localparam int NFU   = 2;
  localparam int DEPTH = 4;
  localparam int BB    = NFU * 4;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int BW    = NFU * 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirectValid;
  logic [63:0]     redirectAddr;
  logic            doFetch;
  logic [63:0]     fetchAddress;
  logic [BW-1:0]   fetchInstruction;
  logic            doneFetch;
  logic [NFU-1:0]  fuWorking;
  logic            instructionReady;
  logic [BW-1:0]   bundle;
  logic [63:0]     bundleAddr;
  logic [CNTW-1:0] queueCount;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     starveCycles;
`endif

  bundle_fetch_unit #(.NFU(NFU), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirectValid    (redirectValid),
    .redirectAddr     (redirectAddr),
    .doFetch          (doFetch),
    .fetchAddress     (fetchAddress),
    .fetchInstruction (fetchInstruction),
    .doneFetch        (doneFetch),
    .fuWorking        (fuWorking),
    .instructionReady (instructionReady),
    .bundle           (bundle),
    .bundleAddr       (bundleAddr),
    .queueCount       (queueCount)
`ifdef FETCH_PERF_CNT_EN
    ,
    .starveCycles     (starveCycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected FIFO contents as a queue of (address, data) pairs.
  typedef struct {
    logic [63:0]   addr;
    logic [BW-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  logic          m_busy, m_discard, m_holdoff, m_dofetch, m_ready;
  logic [63:0]   m_pc, m_faddr, m_baddr;
  logic [BW-1:0] m_bundle;
  logic [31:0]   m_starve;

  // MMU responder and stimulus controls
  logic           mmu_pending;
  int             mmu_cnt;
  int             mmu_lat;
  logic           rand_lat;
  logic           force_done;
  logic [NFU-1:0] fuw_drv;
  logic           prev_ready;
  logic [63:0]    fetch_log[$];
  logic [63:0]    issue_log[$];

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_discard = 0; m_holdoff = 0; m_dofetch = 0; m_ready = 0;
    m_pc = '0; m_faddr = '0; m_baddr = '0; m_bundle = '0; m_starve = '0;
  endtask

  task automatic model_eval(input logic redir, input logic [63:0] raddr, input logic done,
                            input logic [BW-1:0] data, input logic [NFU-1:0] fuw);
    logic push, issue, newf;
    ent_t e;
    push  = m_busy && done && !m_discard && !redir;
    issue = (m_q.size() > 0) && (fuw == '0) && !m_holdoff && !redir;
    newf  = !m_busy && (m_q.size() < DEPTH) && !redir;
    if ((fuw == '0) && (m_q.size() == 0) && !redir && (m_starve != 32'hFFFF_FFFF))
      m_starve = m_starve + 1;
    m_ready = issue;
    if (issue) begin
      e = m_q.pop_front();
      m_bundle = e.data;
      m_baddr  = e.addr;
    end
    if (push) begin
      e.addr = m_faddr;
      e.data = data;
      m_q.push_back(e);
      m_pc = m_pc + 64'(BB);
    end
    if (redir) begin
      m_q.delete();
      m_pc = raddr & ~64'(BB - 1);
    end
    m_holdoff = issue;
    m_dofetch = newf;
    if (newf) m_faddr = m_pc;
    if (m_busy && done) begin
      m_busy = 0;
      m_discard = 0;
    end else if (m_busy && redir) begin
      m_discard = 1;
    end else if (newf) begin
      m_busy = 1;
    end
  endtask

  task automatic compare_all();
    chk("doFetch", 128'(doFetch), 128'(m_dofetch));
    chk("fetchAddress", 128'(fetchAddress), 128'(m_faddr));
    chk("instructionReady", 128'(instructionReady), 128'(m_ready));
    chk("bundle", 128'(bundle), 128'(m_bundle));
    chk("bundleAddr", 128'(bundleAddr), 128'(m_baddr));
    chk("queueCount", 128'(queueCount), 128'(m_q.size()));
    chk("ready_gap", 128'(instructionReady && prev_ready), 128'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("starveCycles", 128'(starveCycles), 128'(m_starve));
`endif
  endtask

  // One clock cycle: drive inputs at posedge+1, sample at the next posedge+1.
  task automatic step(input logic redir, input logic [63:0] raddr);
    logic          done;
    logic [BW-1:0] data;
    done = 1'b0;
    if (force_done) begin
      done = 1'b1;
      force_done = 1'b0;
    end else if (mmu_pending) begin
      mmu_cnt--;
      if (mmu_cnt <= 0) begin
        done = 1'b1;
        mmu_pending = 1'b0;
      end
    end
    for (int i = 0; i < NFU; i++) data[i*32 +: 32] = $urandom;
    redirectValid    = redir;
    redirectAddr     = raddr;
    doneFetch        = done;
    fetchInstruction = data;
    fuWorking        = fuw_drv;
    model_eval(redir, raddr, done, data, fuw_drv);
    @(posedge clk);
    #1;
    compare_all();
    if (doFetch) begin
      fetch_log.push_back(fetchAddress);
      mmu_pending = 1'b1;
      mmu_cnt = rand_lat ? $urandom_range(1, 5) : mmu_lat;
    end
    if (instructionReady) issue_log.push_back(bundleAddr);
    prev_ready = instructionReady;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirectValid = 1'b0; redirectAddr = '0; doneFetch = 1'b0;
    fetchInstruction = '0; fuWorking = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_doFetch", 128'(doFetch), 128'(0));
    chk("rst_fetchAddress", 128'(fetchAddress), 128'(0));
    chk("rst_ready", 128'(instructionReady), 128'(0));
    chk("rst_bundle", 128'(bundle), 128'(0));
    chk("rst_bundleAddr", 128'(bundleAddr), 128'(0));
    chk("rst_queueCount", 128'(queueCount), 128'(0));
    rst = 1'b1;
    model_reset();
    mmu_pending = 1'b0; mmu_cnt = 0; force_done = 1'b0; prev_ready = 1'b0;
    fetch_log.delete(); issue_log.delete();
  endtask

  initial begin
    rand_lat = 1'b0; mmu_lat = 3; fuw_drv = '0;

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    mmu_lat = 8;
    repeat (5) step(1'b0, '0);
    chk("starve5", 128'(starveCycles), 128'(5));
    mmu_lat = 3;
`endif

    // Basic fetch and issue order, idle FUs, 3-cycle MMU
    do_reset();
    repeat (25) step(1'b0, '0);
    chk("t1_nfetch", 128'(fetch_log.size() >= 3), 128'(1));
    chk("t1_fetch0", 128'(fetch_log[0]), 128'(64'h0));
    chk("t1_fetch1", 128'(fetch_log[1]), 128'(64'h8));
    chk("t1_fetch2", 128'(fetch_log[2]), 128'(64'h10));
    chk("t1_nissue", 128'(issue_log.size() >= 3), 128'(1));
    chk("t1_issue0", 128'(issue_log[0]), 128'(64'h0));
    chk("t1_issue1", 128'(issue_log[1]), 128'(64'h8));
    chk("t1_issue2", 128'(issue_log[2]), 128'(64'h10));

    // Busy FUs fill the FIFO, then drain in order
    do_reset();
    fuw_drv = 2'b01;
    for (int i = 0; i < 80 && queueCount != CNTW'(DEPTH); i++) step(1'b0, '0);
    chk("t2_full", 128'(queueCount), 128'(DEPTH));
    repeat (5) begin
      step(1'b0, '0);
      chk("t2_nofetch", 128'(doFetch), 128'(0));
    end
    fuw_drv = '0;
    issue_log.delete();
    repeat (30) step(1'b0, '0);
    chk("t2_nissue", 128'(issue_log.size() >= 4), 128'(1));
    chk("t2_issue0", 128'(issue_log[0]), 128'(64'h0));
    chk("t2_issue1", 128'(issue_log[1]), 128'(64'h8));
    chk("t2_issue2", 128'(issue_log[2]), 128'(64'h10));
    chk("t2_issue3", 128'(issue_log[3]), 128'(64'h18));

    // Redirect while waiting, completion arrives the following cycle
    do_reset();
    for (int i = 0; i < 50 && !(mmu_pending && mmu_cnt == 2); i++) step(1'b0, '0);
    chk("t3_inwait", 128'(mmu_pending && mmu_cnt == 2), 128'(1));
    fetch_log.delete(); issue_log.delete();
    step(1'b1, 64'h1004);
    step(1'b0, '0);
    chk("t3_flushed", 128'(queueCount), 128'(0));
    repeat (20) step(1'b0, '0);
    chk("t3_fetch0", 128'(fetch_log[0]), 128'(64'h1000));
    chk("t3_issue0", 128'(issue_log[0]), 128'(64'h1000));

    // Redirect and completion in the same cycle with two entries queued
    do_reset();
    fuw_drv = 2'b01;
    for (int i = 0; i < 80 && !(queueCount == CNTW'(2) && mmu_pending && mmu_cnt == 1); i++)
      step(1'b0, '0);
    chk("t4_setup", 128'(queueCount == CNTW'(2) && mmu_pending && mmu_cnt == 1), 128'(1));
    fuw_drv = '0;
    fetch_log.delete();
    step(1'b1, 64'h2000);
    chk("t4_noready", 128'(instructionReady), 128'(0));
    chk("t4_count", 128'(queueCount), 128'(0));
    repeat (6) step(1'b0, '0);
    chk("t4_fetch0", 128'(fetch_log[0]), 128'(64'h2000));

    // Asynchronous reset in the middle of a fetch
    do_reset();
    for (int i = 0; i < 20 && !mmu_pending; i++) step(1'b0, '0);
    repeat (8) step(1'b0, '0);
    for (int i = 0; i < 20 && !mmu_pending; i++) step(1'b0, '0);
    #2 rst = 1'b0;
    #1;
    chk("t5_doFetch", 128'(doFetch), 128'(0));
    chk("t5_fetchAddress", 128'(fetchAddress), 128'(0));
    chk("t5_ready", 128'(instructionReady), 128'(0));
    chk("t5_bundle", 128'(bundle), 128'(0));
    chk("t5_bundleAddr", 128'(bundleAddr), 128'(0));
    chk("t5_queueCount", 128'(queueCount), 128'(0));
    model_reset();
    mmu_pending = 1'b0; prev_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    force_done = 1'b1;
    fetch_log.delete(); issue_log.delete();
    repeat (12) step(1'b0, '0);
    chk("t5_nfetch", 128'(fetch_log.size() >= 1), 128'(1));
    chk("t5_fetch0", 128'(fetch_log[0]), 128'(64'h0));

    // Random traffic: busy FUs, variable MMU latency, occasional redirects (incl. near wrap)
    do_reset();
    rand_lat = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic        redir;
      logic [63:0] raddr;
      fuw_drv = ($urandom_range(0, 1) == 0) ? '0 : NFU'($urandom);
      redir = ($urandom_range(0, 29) == 0);
      raddr = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) raddr = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      step(redir, raddr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bundle_fetch_unit.md
Name: bundle_fetch_unit

Overview:
Fetch front-end that sits directly upstream of the functional-unit array. It holds the fetch PC and runs the doFetch/doneFetch handshake with the instruction MMU. Fetched bundles go into a small FIFO, and the unit releases one bundle at a time to the FUs with a one-cycle instructionReady pulse whenever they are idle. A redirect input takes a new PC and flushes all in-flight work.

Parameters:
NFU, 2, number of functional units; bundle width is NFU*32 bits and bundle stride is NFU*4 bytes
DEPTH, 4, FIFO depth in bundles; must be a power of two and at least 2
localparam BUNDLEBYTES = NFU*4; OFFBITS = $clog2(BUNDLEBYTES); CNTW = $clog2(DEPTH+1)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  asynchronous, active-low reset (0 = reset)
redirectValid  input  1  one-cycle request to restart fetch at redirectAddr
redirectAddr  input  64  new fetch PC; low OFFBITS bits ignored (forced to 0)
doFetch  output  1  one-cycle fetch request to the MMU
fetchAddress  output  64  bundle address; stable from the doFetch pulse until doneFetch
fetchInstruction  input  NFU*32  bundle data; valid only in the cycle doneFetch=1
doneFetch  input  1  one-cycle fetch completion from the MMU
fuWorking  input  NFU  per-FU busy flags
instructionReady  output  1  one-cycle pulse; bundle/bundleAddr valid
bundle  output  NFU*32  issued bundle; held until the next issue
bundleAddr  output  64  address of the issued bundle; held until the next issue
queueCount  output  CNTW  number of FIFO entries currently occupied

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: doFetch=0, fetchAddress=0, instructionReady=0, bundle=0, bundleAddr=0, queueCount=0.
  - Internal: FSM=IDLE, pc=0, FIFO pointers=0, discard=0, holdoff=0.
  - A reset mid-fetch abandons the request. A doneFetch arriving after reset deasserts while the FSM is IDLE is ignored.
- Fetch FSM states: IDLE, WAIT.
  - IDLE -> WAIT when queueCount < DEPTH and redirectValid=0. In that same cycle: doFetch=1 and fetchAddress=pc.
  - WAIT, on doneFetch=1 with discard=0: push {fetchInstruction, fetchAddress} into the FIFO, pc <= pc + BUNDLEBYTES (wraps modulo 2^64), go to IDLE.
  - WAIT, on doneFetch=1 with discard=1: drop the data, clear discard, go to IDLE. pc is not advanced.
  - At most one outstanding fetch. doFetch is never asserted while in WAIT.
  - A push into a full FIFO cannot occur, because a fetch is only issued when a free slot is guaranteed.
- Issue:
  - Fires when queueCount>0, fuWorking==0, holdoff=0 and redirectValid=0.
  - Registered response the next cycle: instructionReady=1, bundle/bundleAddr <= FIFO head, pop.
  - holdoff is set for the one cycle after each issue, so the FUs have time to raise fuWorking. Maximum rate is one bundle per 2 cycles.
- Simultaneous push and pop: both happen; queueCount is unchanged.
- Redirect (highest priority):
  - pc <= {redirectAddr[63:OFFBITS], 0}; FIFO flushed (queueCount=0 next cycle); issue suppressed that cycle.
  - If the FSM is in WAIT and doneFetch=0, set discard=1. If doneFetch=1 in the same cycle, drop that data.
  - FSM goes to IDLE only after the outstanding fetch has completed. The next doFetch uses the new pc.
- Latency: doneFetch at cycle t -> earliest instructionReady at t+2 (push at t+1, issue registered at t+2), given an empty FIFO and idle FUs.

Optional Feature:
Macro: FETCH_PERF_CNT_EN
- With the macro defined: extra output starveCycles (32 bits, reset 0). It increments each cycle in which fuWorking==0 and queueCount==0 and redirectValid=0, and saturates at 0xFFFFFFFF.
- Without the macro: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Release reset; MMU answers doneFetch 3 cycles after each doFetch; FUs idle -> doFetch addresses 0x0, 0x8, 0x10; instructionReady pulses carry bundleAddr 0x0, 0x8, 0x10 in order, never in consecutive cycles.
- Hold fuWorking=2'b01 while fetching -> queueCount rises to 4; doFetch stays 0 while full; release fuWorking -> 4 bundles issue in address order 0x0..0x18.
- Redirect to 0x1004 while in WAIT, then doneFetch the next cycle -> that data is dropped, queueCount=0, next doFetch address=0x1000, first issued bundleAddr=0x1000.
- Redirect and doneFetch in the same cycle with FIFO holding 2 entries -> no instructionReady, queueCount=0, next fetch at the redirect PC.
- Assert rst=0 mid-WAIT asynchronously -> all outputs 0 immediately; a stray doneFetch after release is ignored; first doFetch address=0x0.
- With FETCH_PERF_CNT_EN, 5 idle-empty cycles after reset -> starveCycles=5.
